// File: rtl/one_hot_rr_sched.sv
// Round-robin grant of one shared resource to N requesters; req->grant 1 cycle, release->next grant 2 cycles.
// Owner holds until done or req drop; ONE_HOT_RR_SCHED_TIMEOUT_EN adds a forced release after TIMEOUT_CYC cycles.
module one_hot_rr_sched #(
  parameter int N           = 64,
  parameter int IDX_W       = 6,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx,
  output logic [N-1:0]     grant_oh,
  output logic             timeout
);

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (1 << CNT_W) - 1) begin : g_bad_timeout
    $error("one_hot_rr_sched: TIMEOUT_CYC does not fit in CNT_W");
  end
  if (N < 2 || N > 64 || (1 << IDX_W) < N || (1 << (IDX_W - 1)) >= N) begin : g_bad_width
    $error("one_hot_rr_sched: IDX_W must equal ceil(log2(N))");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic             grant_valid_d;
  logic [IDX_W-1:0] grant_idx_d;
  logic [N-1:0]     grant_oh_d;
  logic             timeout_d;

  logic             any_req;
  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] cand;
  logic             release_now;

  // Scan starts one past the previous winner, so the last owner is visited last.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((32'(last_ptr_q) + 32'(k)) % 32'(N));
      if (!any_req && req[cand]) begin
        any_req = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign release_now = done || !req[grant_idx];

  always_comb begin
    state_d       = state_q;
    last_ptr_d    = last_ptr_q;
    hold_cnt_d    = hold_cnt_q;
    grant_valid_d = 1'b0;
    grant_idx_d   = '0;
    timeout_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d       = BUSY;
          grant_valid_d = 1'b1;
          grant_idx_d   = win_idx;
          last_ptr_d    = win_idx;
          hold_cnt_d    = '0;
        end
      end
      BUSY: begin
        if (hold_cnt_q != {CNT_W{1'b1}}) hold_cnt_d = hold_cnt_q + 1'b1;
        if (release_now) begin
          state_d = IDLE;
        end
`ifdef ONE_HOT_RR_SCHED_TIMEOUT_EN
        else if (hold_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end
`endif
        else begin
          grant_valid_d = 1'b1;
          grant_idx_d   = grant_idx;
        end
      end
      default: state_d = IDLE;
    endcase
    grant_oh_d = grant_valid_d ? ({{(N-1){1'b0}}, 1'b1} << grant_idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_ptr_q  <= IDX_W'(N - 1);
      hold_cnt_q  <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      grant_oh    <= '0;
      timeout     <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_ptr_q  <= last_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      grant_valid <= grant_valid_d;
      grant_idx   <= grant_idx_d;
      grant_oh    <= grant_oh_d;
      timeout     <= timeout_d;
    end
  end

endmodule

// File: tb/tb_one_hot_rr_sched.sv
// Directed and random checks of one_hot_rr_sched against an owner/last-winner reference model.
module tb_one_hot_rr_sched;
  localparam int N  = 64;
  localparam int TO = 8;
`ifdef ONE_HOT_RR_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] req;
  logic         done;
  logic         grant_valid;
  logic [5:0]   grant_idx;
  logic [N-1:0] grant_oh;
  logic         timeout;

  int checks   = 0;
  int failures = 0;

  // Reference model: current owner (-1 when none), last winner, cycles held.
  int m_owner;
  int m_last;
  int m_held;
  bit m_to;

  one_hot_rr_sched #(.N(N), .IDX_W(6), .TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant_valid(grant_valid), .grant_idx(grant_idx),
    .grant_oh(grant_oh), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] onehot(input int i);
    logic [63:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = N - 1;
    m_held  = 0;
    m_to    = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, "_valid"}, 64'(grant_valid), 64'(m_owner >= 0));
    check({tag, "_idx"},   64'(grant_idx),   (m_owner >= 0) ? 64'(m_owner) : 64'd0);
    check({tag, "_oh"},    grant_oh,         onehot(m_owner));
    check({tag, "_to"},    64'(timeout),     64'(m_to));
  endtask

  // One clock: predict from pre-edge inputs, advance, then compare.
  task automatic step(input string tag);
    int nxt;
    bit to;
    nxt = m_owner;
    to  = 1'b0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (nxt < 0 && req[j]) begin
          nxt    = j;
          m_last = j;
          m_held = 0;
        end
      end
    end else if (done || !req[m_owner]) begin
      nxt = -1;
    end else if (TO_EN && m_held == TO - 1) begin
      nxt = -1;
      to  = 1'b1;
    end else begin
      m_held++;
    end
    @(posedge clk);
    #1;
    m_owner = nxt;
    m_to    = to;
    check_model(tag);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    model_reset();
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int n_to;

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    model_reset();

    // 1: reset with no requests, then release mid-cycle
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check_model("reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step("post_reset_idle");

    // 2: single requester, 1-cycle latency, done releases
    req = 64'h1;
    step("single_grant");
    check("single_idx0", 64'(grant_idx), 64'd0);
    check("single_oh", grant_oh, 64'h1);
    repeat (3) step("single_hold");
    done = 1'b1;
    step("single_done");
    check("single_released", 64'(grant_valid), 64'd0);
    done = 1'b0;
    req  = '0;
    step("single_idle");

    // 3: all requesting, done on every grant, sequence 0..63 then wrap to 0
    do_reset(2);
    req = '1;
    for (int i = 0; i <= N; i++) begin
      step("rr_grant");
      check("rr_seq", 64'(grant_idx), 64'(i % N));
      done = 1'b1;
      step("rr_dead");
      done = 1'b0;
    end

    // 4: owner 5 with 3,5,9 pending; done and req[3] change together
    req = 64'h20;
    step("own5_grant");
    check("own5_idx", 64'(grant_idx), 64'd5);
    req = 64'h228;
    step("own5_hold");
    done = 1'b1;
    req  = 64'h220;
    step("own5_release");
    check("own5_dead", 64'(grant_valid), 64'd0);
    done = 1'b0;
    step("after5");
    check("after5_idx", 64'(grant_idx), 64'd9);

    // 5: owner drops its request without done, then async reset mid-grant
    req = 64'h8;
    step("drop_release");
    check("drop_dead", 64'(grant_valid), 64'd0);
    step("drop_regrant");
    check("drop_regrant_idx", 64'(grant_idx), 64'd3);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_model("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) req = '0;
      else req = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      done = ($urandom_range(3) == 0);
      step("random");
    end
    done = 1'b0;
    req  = '0;
    step("random_drain");
    step("random_drain");

    // 6: owner never releases
    req  = 64'h80;
    n_to = 0;
    step("hog_grant");
    check("hog_idx", 64'(grant_idx), 64'd7);
    for (int i = 0; i < 999; i++) begin
      step("hog");
      if (timeout) n_to++;
    end
    if (TO_EN) begin
      check("hog_timeouts", 64'(n_to), 64'(999 / (TO + 1)));
    end else begin
      check("hog_held_1000", 64'(grant_valid), 64'd1);
      check("hog_no_timeout", 64'(n_to), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
